alu_sequencer: RTL and testbench
================================

Name: alu_sequencer

Overview:
Multi-cycle issue/writeback controller that drives the ALU (the initiator side of the ALU interface).
- Accepts one MIPS-I instruction at a time via valid/ready.
- Reads operands through a single register-file read port and builds the alu_op/operand bundle.
- Captures write_rd/branch_condition, writes the result back and reports branch outcome.
- Sits between fetch and the register file in the non-pipelined core.

Parameters:
RF_AW, 5, register-file address width (32 registers)
LINK_REG, 31, destination register for BLTZAL/BGEZAL link

Ports:
clk  in  1  core clock
reset_n  in  1  asynchronous active-low reset
instr_valid  in  1  instruction offered
instr_ready  out  1  sequencer idle, can accept
instr  in  32  MIPS instruction word
pc  in  32  address of instr
rf_raddr  out  5  register-file read address (combinational read)
rf_rdata  in  32  register-file read data, valid same cycle
rf_we  out  1  register-file write enable (1-cycle pulse)
rf_waddr  out  5  write address
rf_wdata  out  32  write data
alu_rs  out  32  ALU read_rs operand
alu_rt  out  32  ALU read_rt operand
alu_sa  out  5  ALU shift amount
alu_op  out  5  ALU operation, encodings from params.vh (*_alu_op)
alu_result  in  32  ALU write_rd
alu_branch  in  1  ALU branch_condition
done  out  1  1-cycle pulse, instruction retired
branch_taken  out  1  valid with done
branch_target  out  32  valid with done: pc+4+(sext(imm16)<<2)
illegal  out  1  valid with done: unsupported encoding

Behaviour:
- Reset (async, reset_n=0): state IDLE; instr_ready=1; all other outputs 0. Asserting reset mid-instruction aborts it with no rf write and no done.
- FSM: IDLE -> RD_RS -> RD_RT -> EXEC -> WB -> IDLE. Fixed latency: accept in cycle 0, done in cycle 4, instr_ready high again in cycle 5. instr_ready=1 only in IDLE.
- IDLE:
  - On instr_valid&instr_ready, latch instr and pc.
  - Decode to alu_op, dest, imm_mode, branch and link flags.
- RD_RS: rf_raddr=rs; latch rf_rdata into alu_rs.
- RD_RT: rf_raddr=rt.
  - R-type/BEQ/BNE: alu_rt=rf_rdata.
  - ANDI/ORI/XORI: alu_rt={16'b0,imm16}.
  - REGIMM: alu_rt=0.
  - alu_sa=instr[10:6].
- EXEC:
  - alu_rs, alu_rt, alu_sa and alu_op are registered and stable for the whole cycle.
  - Sample alu_result and alu_branch at the end of EXEC.
- WB:
  - rf_we=1 if a destination exists and dest!=0.
  - R-type dest=rd; imm ops dest=rt; AL branches dest=LINK_REG with wdata=pc+8, written regardless of outcome.
  - done=1; branch_taken=captured alu_branch for branch ops, else 0.
- Decode:
  - R-type (opcode 0), funct: 20 ADD, 21 ADDU, 24 AND, 27 NOR, 25 OR, 00 SLL, 04 SLLV, 2A SLT, 2B SLTU, 03 SRA, 07 SRAV, 22 SUB, 23 SUBU, 26 XOR.
  - Opcode: 0C ANDI, 0D ORI, 0E XORI, 04 BEQ, 05 BNE.
  - Opcode 01 (REGIMM), rt field: 00 BLTZ, 01 BGEZ, 10 BLTZAL, 11 BGEZAL. All values hex.
- Illegal: any other encoding. The instruction still traverses all states and pulses done with illegal=1, rf_we=0, branch_taken=0.
- Arithmetic: branch_target and pc+8 are 32-bit modulo add; wrap at 32'hFFFFFFFC is silent.
- instr_valid while busy is ignored (no latch).

Optional Feature:
Macro ALU_SEQ_OVF_TRAP_EN.
- Defined: for ADD/SUB only, the sequencer computes signed overflow from alu_rs, alu_rt and alu_result sign bits. On overflow, rf_we is suppressed in WB and the extra output ovf_trap (1 bit) pulses with done.
- Not defined: no ovf_trap port; ADD/SUB always write back, same as ADDU/SUBU.

Test Plan:
- Reset then ADD $3,$1,$2 (instr 00221820), $1=5, $2=7: done at cycle 4, rf_we with waddr=3, wdata=12, alu_op=ADD_alu_op held in EXEC.
- ORI $4,$0,0x8001 (34048001): alu_rt=00008001, rf wdata=00008001 to reg 4; ADD with rd=0 gives no rf_we, done still pulses.
- BEQ $1,$2,+3 at pc=00000100 with $1==$2: branch_taken=1, target=00000110, rf_we=0; repeat with $1!=$2: branch_taken=0.
- BLTZAL $5 (04B0FFFF) with $5=80000000, pc=00000200: rf write reg 31 = 00000208, branch_taken=1, target=00000200.
- Illegal opcode 3F: done with illegal=1, no write. Pulse reset_n low during EXEC: outputs 0, instr_ready=1, no done.
- ALU_SEQ_OVF_TRAP_EN: ADD of 7FFFFFFF+1: ovf_trap=1, rf_we=0; without macro: wdata=80000000.

Source files
------------

// File: rtl/alu_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// +-------------------------------------------------------------------------+
// | alu_sequencer: multi-cycle MIPS-I issue/writeback controller for the ALU |
// | Optional: ALU_SEQ_OVF_TRAP_EN adds ADD/SUB signed-overflow trap.          |
// | Revision: 1.0                                                             |
// +-------------------------------------------------------------------------+
module alu_sequencer #(
  parameter int RF_AW    = 5,
  parameter int LINK_REG = 31
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             instr_valid,
  output logic             instr_ready,
  input  logic [31:0]      instr,
  input  logic [31:0]      pc,
  output logic [RF_AW-1:0] rf_raddr,
  input  logic [31:0]      rf_rdata,
  output logic             rf_we,
  output logic [RF_AW-1:0] rf_waddr,
  output logic [31:0]      rf_wdata,
  output logic [31:0]      alu_rs,
  output logic [31:0]      alu_rt,
  output logic [4:0]       alu_sa,
  output logic [4:0]       alu_op,
  input  logic [31:0]      alu_result,
  input  logic             alu_branch,
  output logic             done,
  output logic             branch_taken,
  output logic [31:0]      branch_target,
  output logic             illegal
`ifdef ALU_SEQ_OVF_TRAP_EN
  ,
  output logic             ovf_trap
`endif
);

  localparam logic [4:0] c_ALU_ADD  = 5'd0;
  localparam logic [4:0] c_ALU_ADDU = 5'd1;
  localparam logic [4:0] c_ALU_SUB  = 5'd2;
  localparam logic [4:0] c_ALU_SUBU = 5'd3;
  localparam logic [4:0] c_ALU_AND  = 5'd4;
  localparam logic [4:0] c_ALU_OR   = 5'd5;
  localparam logic [4:0] c_ALU_XOR  = 5'd6;
  localparam logic [4:0] c_ALU_NOR  = 5'd7;
  localparam logic [4:0] c_ALU_SLT  = 5'd8;
  localparam logic [4:0] c_ALU_SLTU = 5'd9;
  localparam logic [4:0] c_ALU_SLL  = 5'd10;
  localparam logic [4:0] c_ALU_SLLV = 5'd11;
  localparam logic [4:0] c_ALU_SRA  = 5'd12;
  localparam logic [4:0] c_ALU_SRAV = 5'd13;
  localparam logic [4:0] c_ALU_BEQ  = 5'd14;
  localparam logic [4:0] c_ALU_BNE  = 5'd15;
  localparam logic [4:0] c_ALU_BLTZ = 5'd16;
  localparam logic [4:0] c_ALU_BGEZ = 5'd17;

  localparam logic [5:0] c_OPC_SPECIAL = 6'h00;
  localparam logic [5:0] c_OPC_REGIMM  = 6'h01;
  localparam logic [5:0] c_OPC_BEQ     = 6'h04;
  localparam logic [5:0] c_OPC_BNE     = 6'h05;
  localparam logic [5:0] c_OPC_ANDI    = 6'h0C;
  localparam logic [5:0] c_OPC_ORI     = 6'h0D;
  localparam logic [5:0] c_OPC_XORI    = 6'h0E;

  localparam logic [4:0] c_RT_BLTZ   = 5'h00;
  localparam logic [4:0] c_RT_BGEZ   = 5'h01;
  localparam logic [4:0] c_RT_BLTZAL = 5'h10;
  localparam logic [4:0] c_RT_BGEZAL = 5'h11;

  localparam logic [RF_AW-1:0] c_LINK = RF_AW'(LINK_REG);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RD_RS = 3'd1,
    S_RD_RT = 3'd2,
    S_EXEC  = 3'd3,
    S_WB    = 3'd4
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [4:0]       w_op;
  logic [RF_AW-1:0] w_dest;
  logic             w_has_dest;
  logic             w_imm_mode;
  logic             w_regimm;
  logic             w_branch;
  logic             w_link;
  logic             w_illegal;

  logic [4:0]       r_rs;
  logic [4:0]       r_rt;
  logic [15:0]      r_imm16;
  logic [31:0]      r_pc;
  logic [RF_AW-1:0] r_dest;
  logic             r_has_dest;
  logic             r_imm_mode;
  logic             r_regimm;
  logic             r_branch;
  logic             r_link;
  logic             r_illegal;
  logic [31:0]      r_result;
  logic             r_alu_br;

  logic [31:0]      w_pc_plus8;
  logic [31:0]      w_target;
  logic             w_ovf;

  always_comb begin
    w_op       = c_ALU_ADDU;
    w_illegal  = 1'b0;
    w_has_dest = 1'b0;
    w_dest     = RF_AW'(instr[15:11]);
    w_imm_mode = 1'b0;
    w_regimm   = 1'b0;
    w_branch   = 1'b0;
    w_link     = 1'b0;
    case (instr[31:26])
      c_OPC_SPECIAL: begin
        w_has_dest = 1'b1;
        case (instr[5:0])
          6'h20:   w_op = c_ALU_ADD;
          6'h21:   w_op = c_ALU_ADDU;
          6'h24:   w_op = c_ALU_AND;
          6'h27:   w_op = c_ALU_NOR;
          6'h25:   w_op = c_ALU_OR;
          6'h00:   w_op = c_ALU_SLL;
          6'h04:   w_op = c_ALU_SLLV;
          6'h2A:   w_op = c_ALU_SLT;
          6'h2B:   w_op = c_ALU_SLTU;
          6'h03:   w_op = c_ALU_SRA;
          6'h07:   w_op = c_ALU_SRAV;
          6'h22:   w_op = c_ALU_SUB;
          6'h23:   w_op = c_ALU_SUBU;
          6'h26:   w_op = c_ALU_XOR;
          default: begin
            w_illegal  = 1'b1;
            w_has_dest = 1'b0;
          end
        endcase
      end
      c_OPC_ANDI, c_OPC_ORI, c_OPC_XORI: begin
        w_op       = (instr[31:26] == c_OPC_ANDI) ? c_ALU_AND :
                     (instr[31:26] == c_OPC_ORI)  ? c_ALU_OR  : c_ALU_XOR;
        w_imm_mode = 1'b1;
        w_has_dest = 1'b1;
        w_dest     = RF_AW'(instr[20:16]);
      end
      c_OPC_BEQ: begin
        w_op     = c_ALU_BEQ;
        w_branch = 1'b1;
      end
      c_OPC_BNE: begin
        w_op     = c_ALU_BNE;
        w_branch = 1'b1;
      end
      c_OPC_REGIMM: begin
        w_regimm = 1'b1;
        w_branch = 1'b1;
        case (instr[20:16])
          c_RT_BLTZ: w_op = c_ALU_BLTZ;
          c_RT_BGEZ: w_op = c_ALU_BGEZ;
          c_RT_BLTZAL, c_RT_BGEZAL: begin
            w_op       = (instr[20:16] == c_RT_BLTZAL) ? c_ALU_BLTZ : c_ALU_BGEZ;
            w_link     = 1'b1;
            w_has_dest = 1'b1;
            w_dest     = c_LINK;
          end
          default: begin
            w_illegal = 1'b1;
            w_regimm  = 1'b0;
            w_branch  = 1'b0;
          end
        endcase
      end
      default: w_illegal = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rs       <= '0;
      r_rt       <= '0;
      r_imm16    <= '0;
      r_pc       <= '0;
      r_dest     <= '0;
      r_has_dest <= 1'b0;
      r_imm_mode <= 1'b0;
      r_regimm   <= 1'b0;
      r_branch   <= 1'b0;
      r_link     <= 1'b0;
      r_illegal  <= 1'b0;
      r_result   <= '0;
      r_alu_br   <= 1'b0;
      alu_rs     <= '0;
      alu_rt     <= '0;
      alu_sa     <= '0;
      alu_op     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (instr_valid) begin
            r_rs       <= instr[25:21];
            r_rt       <= instr[20:16];
            r_imm16    <= instr[15:0];
            r_pc       <= pc;
            r_dest     <= w_dest;
            r_has_dest <= w_has_dest;
            r_imm_mode <= w_imm_mode;
            r_regimm   <= w_regimm;
            r_branch   <= w_branch;
            r_link     <= w_link;
            r_illegal  <= w_illegal;
            alu_op     <= w_op;
          end
        end
        S_RD_RS: alu_rs <= rf_rdata;
        S_RD_RT: begin
          // Shift amount occupies instr[10:6], which lies inside the kept imm16.
          alu_sa <= r_imm16[10:6];
          if (r_imm_mode) begin
            alu_rt <= {16'h0000, r_imm16};
          end else if (r_regimm) begin
            alu_rt <= '0;
          end else begin
            alu_rt <= rf_rdata;
          end
        end
        S_EXEC: begin
          r_result <= alu_result;
          r_alu_br <= alu_branch;
        end
        default: ;
      endcase
    end
  end

  assign w_pc_plus8 = r_pc + 32'd8;
  assign w_target   = r_pc + 32'd4 + {{14{r_imm16[15]}}, r_imm16, 2'b00};

`ifdef ALU_SEQ_OVF_TRAP_EN
  logic r_ovf_chk;
  logic r_is_sub;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ovf_chk <= 1'b0;
      r_is_sub  <= 1'b0;
    end else if (r_state == S_IDLE && instr_valid) begin
      r_ovf_chk <= !w_illegal && (w_op == c_ALU_ADD || w_op == c_ALU_SUB);
      r_is_sub  <= (w_op == c_ALU_SUB);
    end
  end

  // Operands stay in alu_rs/alu_rt through WB, so overflow is judged there.
  assign w_ovf    = r_ovf_chk && (alu_rs[31] != r_result[31]) &&
                    (r_is_sub ? (alu_rs[31] != alu_rt[31]) : (alu_rs[31] == alu_rt[31]));
  assign ovf_trap = (r_state == S_WB) && w_ovf;
`else
  assign w_ovf = 1'b0;
`endif

  always_comb begin
    w_next        = r_state;
    instr_ready   = 1'b0;
    rf_raddr      = '0;
    rf_we         = 1'b0;
    rf_waddr      = '0;
    rf_wdata      = '0;
    done          = 1'b0;
    branch_taken  = 1'b0;
    branch_target = '0;
    illegal       = 1'b0;
    case (r_state)
      S_IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) w_next = S_RD_RS;
      end
      S_RD_RS: begin
        rf_raddr = RF_AW'(r_rs);
        w_next   = S_RD_RT;
      end
      S_RD_RT: begin
        rf_raddr = RF_AW'(r_rt);
        w_next   = S_EXEC;
      end
      S_EXEC: w_next = S_WB;
      S_WB: begin
        w_next        = S_IDLE;
        done          = 1'b1;
        rf_we         = r_has_dest && (r_dest != '0) && !w_ovf;
        rf_waddr      = r_dest;
        rf_wdata      = r_link ? w_pc_plus8 : r_result;
        branch_taken  = r_branch && r_alu_br;
        branch_target = w_target;
        illegal       = r_illegal;
      end
      default: w_next = S_IDLE;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// +-------------------------------------------------------------------------+
// | tb_alu_sequencer: randomized self-checking bench with reference model   |
// | Revision: 1.0                                                             |
// +-------------------------------------------------------------------------+
module tb_alu_sequencer;

  // ALU operation encodings shared with the core (params.vh)
  localparam logic [4:0] A_ADD  = 5'd0,  A_ADDU = 5'd1,  A_SUB  = 5'd2,  A_SUBU = 5'd3;
  localparam logic [4:0] A_AND  = 5'd4,  A_OR   = 5'd5,  A_XOR  = 5'd6,  A_NOR  = 5'd7;
  localparam logic [4:0] A_SLT  = 5'd8,  A_SLTU = 5'd9,  A_SLL  = 5'd10, A_SLLV = 5'd11;
  localparam logic [4:0] A_SRA  = 5'd12, A_SRAV = 5'd13, A_BEQ  = 5'd14, A_BNE  = 5'd15;
  localparam logic [4:0] A_BLTZ = 5'd16, A_BGEZ = 5'd17;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [4:0]  rf_raddr;
  logic [31:0] rf_rdata;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [31:0] alu_rs;
  logic [31:0] alu_rt;
  logic [4:0]  alu_sa;
  logic [4:0]  alu_op;
  logic [31:0] alu_result;
  logic        alu_branch;
  logic        done;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        illegal;
`ifdef ALU_SEQ_OVF_TRAP_EN
  logic        ovf_trap;
`endif

  always #5 clk = ~clk;

  alu_sequencer #(.RF_AW(5), .LINK_REG(31)) dut (
    .clk(clk), .reset_n(reset_n), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .pc(pc), .rf_raddr(rf_raddr), .rf_rdata(rf_rdata), .rf_we(rf_we),
    .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .alu_rs(alu_rs), .alu_rt(alu_rt),
    .alu_sa(alu_sa), .alu_op(alu_op), .alu_result(alu_result), .alu_branch(alu_branch),
    .done(done), .branch_taken(branch_taken), .branch_target(branch_target),
    .illegal(illegal)
`ifdef ALU_SEQ_OVF_TRAP_EN
    , .ovf_trap(ovf_trap)
`endif
  );

  // Register file environment
  logic [31:0] rf [32] = '{default: 32'h0};
  logic        poke_en = 1'b0;
  logic [4:0]  poke_a  = '0;
  logic [31:0] poke_d  = '0;
  assign rf_rdata = (rf_raddr == 5'd0) ? 32'h0 : rf[rf_raddr];
  always @(posedge clk) begin
    if (rf_we) rf[rf_waddr] <= rf_wdata;
    if (poke_en) rf[poke_a] <= poke_d;
  end

  // ALU environment
  always_comb begin
    alu_result = 32'h0;
    alu_branch = 1'b0;
    case (alu_op)
      A_ADD, A_ADDU: alu_result = alu_rs + alu_rt;
      A_SUB, A_SUBU: alu_result = alu_rs - alu_rt;
      A_AND:  alu_result = alu_rs & alu_rt;
      A_OR:   alu_result = alu_rs | alu_rt;
      A_XOR:  alu_result = alu_rs ^ alu_rt;
      A_NOR:  alu_result = ~(alu_rs | alu_rt);
      A_SLT:  alu_result = {31'd0, $signed(alu_rs) < $signed(alu_rt)};
      A_SLTU: alu_result = {31'd0, alu_rs < alu_rt};
      A_SLL:  alu_result = alu_rt << alu_sa;
      A_SLLV: alu_result = alu_rt << alu_rs[4:0];
      A_SRA:  alu_result = $unsigned($signed(alu_rt) >>> alu_sa);
      A_SRAV: alu_result = $unsigned($signed(alu_rt) >>> alu_rs[4:0]);
      A_BEQ:  alu_branch = (alu_rs == alu_rt);
      A_BNE:  alu_branch = (alu_rs != alu_rt);
      A_BLTZ: alu_branch = alu_rs[31];
      A_BGEZ: alu_branch = !alu_rs[31];
      default: ;
    endcase
  end

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %08h expected %08h", nm, act, exp);
    end
  endtask

  typedef struct packed {
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        is_br;
    logic        taken;
    logic [31:0] target;
    logic        ill;
    logic [4:0]  op;
    logic [31:0] ers;
    logic [31:0] ert;
    logic [4:0]  sa;
    logic        ovf;
  } exp_t;

  function automatic logic [31:0] rdreg(input logic [4:0] a);
    return (a == 5'd0) ? 32'h0 : rf[a];
  endfunction

  // Instruction semantics straight from the ISA definition
  function automatic exp_t model(input logic [31:0] ins, input logic [31:0] p,
                                 input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    logic [31:0] zi;
    logic signed [31:0] sb;
    logic has;
    logic [4:0] dst;
    e      = '0;
    zi     = {16'h0, ins[15:0]};
    sb     = b;
    has    = 1'b0;
    dst    = 5'd0;
    e.ers  = a;
    e.ert  = b;
    e.sa   = ins[10:6];
    e.target = p + 32'd4 + {{14{ins[15]}}, ins[15:0], 2'b00};
    case (ins[31:26])
      6'h00: begin
        has = 1'b1;
        dst = ins[15:11];
        case (ins[5:0])
          6'h20: begin e.op = A_ADD; e.wdata = a + b;
                   e.ovf = (a[31] == b[31]) && (e.wdata[31] != a[31]); end
          6'h21: begin e.op = A_ADDU; e.wdata = a + b; end
          6'h22: begin e.op = A_SUB; e.wdata = a - b;
                   e.ovf = (a[31] != b[31]) && (e.wdata[31] != a[31]); end
          6'h23: begin e.op = A_SUBU; e.wdata = a - b; end
          6'h24: begin e.op = A_AND;  e.wdata = a & b; end
          6'h25: begin e.op = A_OR;   e.wdata = a | b; end
          6'h26: begin e.op = A_XOR;  e.wdata = a ^ b; end
          6'h27: begin e.op = A_NOR;  e.wdata = ~(a | b); end
          6'h2A: begin e.op = A_SLT;  e.wdata = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0; end
          6'h2B: begin e.op = A_SLTU; e.wdata = (a < b) ? 32'd1 : 32'd0; end
          6'h00: begin e.op = A_SLL;  e.wdata = b << ins[10:6]; end
          6'h04: begin e.op = A_SLLV; e.wdata = b << a[4:0]; end
          6'h03: begin e.op = A_SRA;  e.wdata = sb >>> ins[10:6]; end
          6'h07: begin e.op = A_SRAV; e.wdata = sb >>> a[4:0]; end
          default: begin e.ill = 1'b1; has = 1'b0; end
        endcase
      end
      6'h0C: begin e.op = A_AND; e.ert = zi; e.wdata = a & zi; has = 1'b1; dst = ins[20:16]; end
      6'h0D: begin e.op = A_OR;  e.ert = zi; e.wdata = a | zi; has = 1'b1; dst = ins[20:16]; end
      6'h0E: begin e.op = A_XOR; e.ert = zi; e.wdata = a ^ zi; has = 1'b1; dst = ins[20:16]; end
      6'h04: begin e.op = A_BEQ; e.is_br = 1'b1; e.taken = (a == b); end
      6'h05: begin e.op = A_BNE; e.is_br = 1'b1; e.taken = (a != b); end
      6'h01: begin
        e.ert = 32'h0;
        e.is_br = 1'b1;
        case (ins[20:16])
          5'h00: begin e.op = A_BLTZ; e.taken = a[31]; end
          5'h01: begin e.op = A_BGEZ; e.taken = !a[31]; end
          5'h10: begin e.op = A_BLTZ; e.taken = a[31];  has = 1'b1; dst = 5'd31; e.wdata = p + 32'd8; end
          5'h11: begin e.op = A_BGEZ; e.taken = !a[31]; has = 1'b1; dst = 5'd31; e.wdata = p + 32'd8; end
          default: begin e.ill = 1'b1; e.is_br = 1'b0; end
        endcase
      end
      default: e.ill = 1'b1;
    endcase
`ifndef ALU_SEQ_OVF_TRAP_EN
    e.ovf = 1'b0;
`endif
    e.we    = has && (dst != 5'd0) && !e.ovf;
    e.waddr = dst;
    return e;
  endfunction

  // Per-cycle comparison against the model
  exp_t cur;
  int   ph    = 0;
  bit   busy  = 1'b0;
  int   n_ret = 0;

  always @(negedge clk) begin
    if (!reset_n) begin
      busy = 1'b0;
      chk("rst_ready", {31'd0, instr_ready}, 32'd1);
      chk("rst_outputs_zero",
          {31'd0, |{rf_raddr, rf_we, rf_waddr, rf_wdata, alu_rs, alu_rt, alu_sa, alu_op,
                    done, branch_taken, branch_target, illegal}}, 32'd0);
    end else if (!busy) begin
      chk("idle_ready", {31'd0, instr_ready}, 32'd1);
      chk("idle_done",  {31'd0, done}, 32'd0);
      chk("idle_we",    {31'd0, rf_we}, 32'd0);
      if (instr_valid) begin
        cur  = model(instr, pc, rdreg(instr[25:21]), rdreg(instr[20:16]));
        busy = 1'b1;
        ph   = 0;
      end
    end else begin
      ph++;
      chk("busy_ready", {31'd0, instr_ready}, 32'd0);
      if (ph == 3 && !cur.ill) begin
        chk("exec_alu_op", {27'd0, alu_op}, {27'd0, cur.op});
        chk("exec_alu_rs", alu_rs, cur.ers);
        chk("exec_alu_rt", alu_rt, cur.ert);
        chk("exec_alu_sa", {27'd0, alu_sa}, {27'd0, cur.sa});
      end
      if (ph == 4) begin
        chk("wb_done",    {31'd0, done}, 32'd1);
        chk("wb_illegal", {31'd0, illegal}, {31'd0, cur.ill});
        chk("wb_we",      {31'd0, rf_we}, {31'd0, cur.we});
        if (cur.we) begin
          chk("wb_waddr", {27'd0, rf_waddr}, {27'd0, cur.waddr});
          chk("wb_wdata", rf_wdata, cur.wdata);
        end
        chk("wb_taken", {31'd0, branch_taken}, {31'd0, cur.is_br && cur.taken});
        if (cur.is_br) chk("wb_target", branch_target, cur.target);
`ifdef ALU_SEQ_OVF_TRAP_EN
        chk("wb_ovf_trap", {31'd0, ovf_trap}, {31'd0, cur.ovf});
`endif
        busy = 1'b0;
        n_ret++;
      end else begin
        chk("busy_done", {31'd0, done}, 32'd0);
        chk("busy_we",   {31'd0, rf_we}, 32'd0);
      end
    end
  end

  // Directed-instruction capture
  logic [31:0] d_wdata, d_target, d_rt;
  logic [4:0]  d_waddr, d_op;
  logic        d_we, d_taken, d_ill, d_got, d_ovf;
  int          d_lat;

  task automatic poke(input logic [4:0] a, input logic [31:0] d);
    poke_a  = a;
    poke_d  = d;
    poke_en = 1'b1;
    @(posedge clk);
    #1 poke_en = 1'b0;
  endtask

  task automatic issue(input logic [31:0] ins, input logic [31:0] p);
    int n;
    @(posedge clk);
    #1 instr_valid = 1'b1; instr = ins; pc = p;
    @(posedge clk);
    #1 instr_valid = 1'b0; instr = $urandom; pc = $urandom;
    d_got = 1'b0; d_ovf = 1'b0; d_lat = 0; n = 1;
    while (!d_got && n < 10) begin
      @(negedge clk);
      if (n == 3) begin d_op = alu_op; d_rt = alu_rt; end
      if (done) begin
        d_got = 1'b1; d_lat = n; d_we = rf_we; d_waddr = rf_waddr; d_wdata = rf_wdata;
        d_taken = branch_taken; d_target = branch_target; d_ill = illegal;
`ifdef ALU_SEQ_OVF_TRAP_EN
        d_ovf = ovf_trap;
`endif
      end else begin
        n++;
      end
    end
    chk("issue_done_seen", {31'd0, d_got}, 32'd1);
  endtask

  function automatic logic [5:0] rfunct(input int k);
    case (k)
      0: return 6'h20;  1: return 6'h21;  2: return 6'h24;  3: return 6'h27;
      4: return 6'h25;  5: return 6'h00;  6: return 6'h04;  7: return 6'h2A;
      8: return 6'h2B;  9: return 6'h03;  10: return 6'h07; 11: return 6'h22;
      12: return 6'h23; default: return 6'h26;
    endcase
  endfunction

  function automatic logic [31:0] gen();
    logic [31:0] r;
    int k;
    r = $urandom;
    k = $urandom_range(0, 19);
    case (k)
      0, 1, 2, 3, 4, 5, 6, 7, 8: begin r[31:26] = 6'h00; r[5:0] = rfunct($urandom_range(0, 13)); end
      9:  r[31:26] = 6'h0C;
      10: r[31:26] = 6'h0D;
      11: r[31:26] = 6'h0E;
      12, 13: begin
        r[31:26] = (k == 12) ? 6'h04 : 6'h05;
        if ($urandom_range(0, 1) == 1) r[20:16] = r[25:21];
      end
      14, 15: begin
        r[31:26] = 6'h01;
        case ($urandom_range(0, 3))
          0: r[20:16] = 5'h00;
          1: r[20:16] = 5'h01;
          2: r[20:16] = 5'h10;
          default: r[20:16] = 5'h11;
        endcase
      end
      17: begin r[31:26] = 6'h00; r[5:0] = 6'h02; end
      18: begin r[31:26] = 6'h01; r[20:16] = 5'h02; end
      19: r[31:26] = 6'h3F;
      default: ;
    endcase
    return r;
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] t;
    int dn;
    reset_n = 1'b0; instr_valid = 1'b0; instr = '0; pc = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_instr_ready", {31'd0, instr_ready}, 32'd1);
    chk("reset_done", {31'd0, done}, 32'd0);
    reset_n = 1'b1;

    // ADD $3,$1,$2 with 5 + 7
    poke(5'd1, 32'd5); poke(5'd2, 32'd7);
    issue(32'h00221820, 32'h0);
    chk("add_latency", d_lat, 32'd4);
    chk("add_we", {31'd0, d_we}, 32'd1);
    chk("add_waddr", {27'd0, d_waddr}, 32'd3);
    chk("add_wdata", d_wdata, 32'd12);
    chk("add_exec_op", {27'd0, d_op}, {27'd0, A_ADD});

    // ORI $4,$0,0x8001
    issue(32'h34048001, 32'h4);
    chk("ori_alu_rt", d_rt, 32'h00008001);
    chk("ori_waddr", {27'd0, d_waddr}, 32'd4);
    chk("ori_wdata", d_wdata, 32'h00008001);

    // ADD $0,$1,$2: no write, still retires
    issue(32'h00220020, 32'h8);
    chk("add_r0_we", {31'd0, d_we}, 32'd0);

    // BEQ $1,$2,+3 at 0x100, equal then unequal
    poke(5'd2, 32'd5);
    issue(32'h10220003, 32'h100);
    chk("beq_taken", {31'd0, d_taken}, 32'd1);
    chk("beq_target", d_target, 32'h00000110);
    chk("beq_we", {31'd0, d_we}, 32'd0);
    poke(5'd2, 32'd7);
    issue(32'h10220003, 32'h100);
    chk("beq_not_taken", {31'd0, d_taken}, 32'd0);

    // BLTZAL $5,-1 at 0x200
    poke(5'd5, 32'h80000000);
    issue(32'h04B0FFFF, 32'h200);
    chk("bltzal_we", {31'd0, d_we}, 32'd1);
    chk("bltzal_waddr", {27'd0, d_waddr}, 32'd31);
    chk("bltzal_wdata", d_wdata, 32'h00000208);
    chk("bltzal_taken", {31'd0, d_taken}, 32'd1);
    chk("bltzal_target", d_target, 32'h00000200);

    // Branch target wraps silently
    issue(32'h10000000, 32'hFFFFFFFC);
    chk("wrap_target", d_target, 32'h00000000);
    chk("wrap_taken", {31'd0, d_taken}, 32'd1);

    // Illegal opcode 3F
    issue(32'hFC000000, 32'h300);
    chk("illegal_flag", {31'd0, d_ill}, 32'd1);
    chk("illegal_we", {31'd0, d_we}, 32'd0);
    chk("illegal_taken", {31'd0, d_taken}, 32'd0);

    // ADD 7FFFFFFF + 1
    poke(5'd1, 32'h7FFFFFFF); poke(5'd2, 32'd1);
    issue(32'h00221820, 32'h400);
`ifdef ALU_SEQ_OVF_TRAP_EN
    chk("ovf_trap_pulse", {31'd0, d_ovf}, 32'd1);
    chk("ovf_we", {31'd0, d_we}, 32'd0);
`else
    chk("ovf_add_we", {31'd0, d_we}, 32'd1);
    chk("ovf_add_wdata", d_wdata, 32'h80000000);
`endif

    // Reset asserted during EXEC aborts ADD $7,$1,$2
    poke(5'd7, 32'h0000DEAD);
    @(posedge clk);
    #1 instr_valid = 1'b1; instr = 32'h00223820; pc = 32'h500;
    @(posedge clk);
    #1 instr_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 chk("abort_exec_op", {27'd0, alu_op}, {27'd0, A_ADD});
    reset_n = 1'b0;
    #1;
    chk("abort_ready", {31'd0, instr_ready}, 32'd1);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_alu_op", {27'd0, alu_op}, 32'd0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    dn = 0;
    repeat (8) begin
      @(negedge clk);
      if (done) dn++;
    end
    chk("abort_no_done", dn, 32'd0);
    chk("abort_no_write", rf[7], 32'h0000DEAD);

    // Randomized traffic, including valid held while busy
    for (int i = 1; i < 32; i++) poke(5'(i), $urandom);
    for (int c = 0; c < 1500; c++) begin
      @(posedge clk);
      #1;
      instr_valid = ($urandom_range(0, 3) != 0);
      instr       = gen();
      t           = $urandom;
      pc          = ($urandom_range(0, 15) == 0) ? 32'hFFFFFFFC : {t[31:2], 2'b00};
    end
    @(posedge clk);
    #1 instr_valid = 1'b0;
    repeat (8) @(posedge clk);
    chk("random_retired", {31'd0, n_ret > 150}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
